// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the fetch stage. Defines the
//               prefetch-queue entry (instruction word plus the PC it was
//               fetched from) and the NOP that decode sees on a bubble.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Datapath width the queue entry is built for. Modules that carry a WIDTH
  // parameter must be instantiated with WIDTH == FQ_WIDTH.
  localparam int FQ_WIDTH = 32;

  // addi x0, x0, 0 : the canonical RISC-V NOP, presented whenever the
  // queue has nothing for decode.
  localparam logic [FQ_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  // One prefetch-queue slot.
  typedef struct packed {
    logic [FQ_WIDTH-1:0] instr;
    logic [FQ_WIDTH-1:0] pc;
  } fq_entry_t;

  // Clears the byte-offset bits of an address so fetches stay word aligned.
  function automatic logic [FQ_WIDTH-1:0] word_align(input logic [FQ_WIDTH-1:0] addr);
    return {addr[FQ_WIDTH-1:2], 2'b00};
  endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : DEPTH-entry circular buffer of fq_entry_t used as the
//               prefetch queue between fetch and decode. Head entry is
//               presented combinationally (no bypass of a same-cycle push).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1            clock, rising edge
//   rst        in   1            asynchronous, active-high reset
//   flush      in   1            empty the queue at the next edge
//   push       in   1            write push_data at the tail
//   push_data  in   fq_entry_t   entry to write
//   pop        in   1            retire the head entry (ignored when empty)
//   head       out  fq_entry_t   entry at the read pointer
//   count      out  CLOG2(D)+1   number of valid entries, 0..DEPTH
//   empty      out  1            count == 0
// ============================================================================
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fq_entry_t                push_data,
  input  logic                     pop,
  output fq_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [PTR_W:0] c_full_count = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] c_one        = (PTR_W + 1)'(1);

  // Storage carries no reset: an entry is only ever read once count says
  // it has been written.
  fq_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_push;
  logic w_pop;
  logic w_full;

  assign empty  = (r_count == '0);
  assign w_full = (r_count == c_full_count);

  // A pop on an empty queue is meaningless; a flush overrides both.
  assign w_push = push && !flush;
  assign w_pop  = pop && !empty && !flush;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_one;
        2'b01:   r_count <= r_count - c_one;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

  // The issue logic upstream reserves a slot for every outstanding
  // request, so writing into a full queue means that reservation broke.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    (w_push && w_full) |-> w_pop);

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Fetch stage of the pipelined core. Holds the PC, issues
//               pipelined instruction-memory requests (one-cycle response)
//               and buffers returned instructions in a DEPTH-entry prefetch
//               queue so decode stalls do not stop memory streaming. A
//               redirect from execute flushes the queue and drops any
//               response still on its way.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1      clock, rising edge
//   rst          in   1      asynchronous, active-high reset
//   imem_req     out  1      fetch request this cycle
//   imem_addr    out  WIDTH  fetch address (word aligned)
//   imem_rdata   in   WIDTH  instruction, 1 cycle after an accepted request
//   redirect     in   1      taken branch/jump in execute
//   redirect_pc  in   WIDTH  branch/jump target (low two bits ignored)
//   stallD       in   1      decode not accepting this cycle
//   validD       out  1      head entry valid
//   instrD       out  WIDTH  head instruction, NOP when !validD
//   pcD          out  WIDTH  head PC, 0 when !validD
//   pcplus4D     out  WIDTH  pcD + 4, 0 when !validD
// ============================================================================
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = FQ_WIDTH,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             stallD,
  output logic             validD,
  output logic [WIDTH-1:0] instrD,
  output logic [WIDTH-1:0] pcD,
  output logic [WIDTH-1:0] pcplus4D
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [WIDTH-1:0] c_pc_step    = WIDTH'(4);
  localparam logic [CNT_W:0]   c_depth      = (CNT_W + 1)'(DEPTH);

  // PC of the next request to issue.
  logic [WIDTH-1:0] r_pc;
  // A request was issued last cycle; its word is on imem_rdata now.
  logic             r_inflight;
  // PC of that in-flight request, stored alongside the returned word.
  logic [WIDTH-1:0] r_fetch_pc;
  // Set for the cycle after a redirect: whatever arrives then belongs to
  // the abandoned path.
  logic             r_cancel;

  logic [CNT_W-1:0] w_count;
  logic [CNT_W:0]   w_occupancy;
  logic             w_empty;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic             w_valid;
  fq_entry_t        w_push_data;
  fq_entry_t        w_head;

  // Entries already queued plus the one still in flight. Issuing only when
  // this leaves room guarantees every response has a slot waiting for it.
  assign w_occupancy = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};

  // rst is included so the request line is quiet for the whole reset
  // window, not just from the first edge.
  assign w_issue = !rst && !redirect && (w_occupancy < c_depth);

  // A redirect freezes the queue for its cycle: the word arriving now and
  // the head entry both belong to the wrong path.
  assign w_push  = r_inflight && !r_cancel && !redirect;
  assign w_valid = !w_empty;
  assign w_pop   = w_valid && !stallD && !redirect;

  assign w_push_data.instr = imem_rdata;
  assign w_push_data.pc    = r_fetch_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
      r_fetch_pc <= '0;
      r_cancel   <= 1'b0;
    end else if (redirect) begin
      r_pc       <= word_align(redirect_pc);
      r_inflight <= 1'b0;
      r_cancel   <= 1'b1;
    end else begin
      r_cancel   <= 1'b0;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc <= r_pc;
        // Wraps modulo 2^WIDTH; running off the top of memory is not trapped.
        r_pc       <= r_pc + c_pc_step;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count),
    .empty     (w_empty)
  );

  assign imem_req  = w_issue;
  assign imem_addr = r_pc;

  // Decode sees a clean NOP bubble whenever the queue is empty, so a stale
  // slot is never exposed after a flush or reset.
  assign validD   = w_valid;
  assign instrD   = w_valid ? w_head.instr             : NOP_INSTR;
  assign pcD      = w_valid ? w_head.pc                : '0;
  assign pcplus4D = w_valid ? (w_head.pc + c_pc_step)  : '0;

endmodule : fetch_queue
`default_nettype wire
